load_unit: RTL and testbench

- Reader side of the data-memory interface for the riscv32i core.
- Accepts one load request at a time from the execute stage and issues a word-aligned read to data memory.
- Waits for the response, then extracts, aligns and sign- or zero-extends the result (LB/LH/LW/LBU/LHU).
- Returns the result to writeback, or reports misalignment, illegal funct3 or timeout.

---
 rtl/riscv32i_pkg.sv | 44 ++++
 rtl/load_align.sv | 37 +++
 rtl/load_unit.sv | 161 ++++++++++++++++
 tb/tb_load_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv32i_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : riscv32i_pkg                                                      |
// | Shared types and constants for the riscv32i memory-side units: load funct3 |
// | encodings, the load unit state enum, error codes and request checkers.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package riscv32i_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } load_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_ILLEGAL  = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } load_err_t;

  // funct3 values 3, 6 and 7 have no load meaning in RV32I
  function automatic logic load_f3_illegal(input logic [2:0] f3);
    return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
  endfunction

  function automatic logic load_misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic r;
    r = 1'b0;
    if ((f3 == LH) || (f3 == LHU)) r = off[0];
    else if (f3 == LW)             r = (off != 2'b00);
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : load_align                                                        |
// | Selects the addressed byte/half/word from a memory word and sign- or       |
// | zero-extends it according to the RV32I load funct3.                        |
// | Ports  : rdata  in  32  raw memory word                                    |
// |          off    in  2   byte offset within the word                        |
// |          funct3 in  3   load type                                          |
// |          data   out 32  extended result                                    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module load_align
  import riscv32i_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[{off, 3'b000} +: 8];
    w_half = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{w_byte[7]}}, w_byte};
      LBU:     data = {24'd0, w_byte};
      LH:      data = {{16{w_half[15]}}, w_half};
      LHU:     data = {16'd0, w_half};
      default: data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : load_unit                                                         |
// | Load path of the riscv32i data-memory interface. Accepts one load at a     |
// | time, issues a word-aligned read, extends the returned data and hands it   |
// | to writeback, or reports misalignment / illegal funct3 / timeout.          |
// | Ports  : clk, rst (async active-low)                                       |
// |          ld_*   request from execute (valid/ready, addr, funct3, rd)       |
// |          mem_*  memory read channel (req/gnt, addr, rvalid/rdata)          |
// |          wb_*   one-cycle writeback pulse with rd and data                 |
// |          err_*  one-cycle error pulse with code and faulting address       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module load_unit
  import riscv32i_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  input  logic [4:0]  ld_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_valid,
  output logic [1:0]  err_code,
  output logic [31:0] err_addr
);

  // WAIT cycles are numbered 0..TIMEOUT_CYCLES-1; the last one raises the timeout
  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  load_state_t r_state, w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_f3;
  logic [4:0]  r_rd;
  logic [7:0]  r_cnt;
  logic [31:0] r_wb_data;
  logic        r_err_valid;
  load_err_t   r_err_code;
  logic [31:0] r_err_addr;

  logic        w_accept;
  logic        w_ready;
  logic        w_mem_req;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_capture;
  load_err_t   w_err;
  logic [31:0] w_ext;

  load_align u_align (
    .rdata  (mem_rdata),
    .off    (r_addr[1:0]),
    .funct3 (r_f3),
    .data   (w_ext)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_ready   = 1'b0;
    w_mem_req = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    w_capture = 1'b0;
    w_err     = ERR_NONE;
    case (r_state)
      S_IDLE: begin
        // Held low during an error pulse so ready returns the cycle after it
        w_ready = !r_err_valid;
        if (ld_valid && w_ready) begin
          w_accept = 1'b1;
          if (load_f3_illegal(ld_funct3))
            w_err = ERR_ILLEGAL;
          else if (load_misaligned(ld_funct3, ld_addr[1:0]))
            w_err = ERR_MISALIGN;
          else
            w_next = S_REQ;
        end
      end
      S_REQ: begin
        w_mem_req = 1'b1;
        if (mem_gnt) begin
          w_cnt_clr = 1'b1;
          w_next    = S_WAIT;
        end
      end
      S_WAIT: begin
        // Data arriving on the last allowed cycle beats the timeout
        if (mem_rvalid) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end else if (r_cnt == C_TO_LAST) begin
          w_err  = ERR_TIMEOUT;
          w_next = S_IDLE;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr      <= '0;
      r_f3        <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_wb_data   <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_err_addr  <= '0;
    end else begin
      if (w_accept) begin
        r_addr <= ld_addr;
        r_f3   <= ld_funct3;
        r_rd   <= ld_rd;
      end
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + 8'd1;
      if (w_capture) r_wb_data <= w_ext;
      r_err_valid <= (w_err != ERR_NONE);
      if (w_err != ERR_NONE) begin
        r_err_code <= w_err;
        // Request-time errors report the incoming address; timeouts the latched one
        r_err_addr <= w_accept ? ld_addr : r_addr;
      end
    end
  end

  assign ld_ready  = w_ready;
  assign mem_req   = w_mem_req;
  assign mem_addr  = {r_addr[31:2], 2'b00};
  assign wb_valid  = (r_state == S_RESP) && (r_rd != 5'd0);
  assign wb_rd     = r_rd;
  assign wb_data   = r_wb_data;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_load_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_load_unit                                                      |
// | Directed self-checking bench for load_unit (TIMEOUT_CYCLES = 4).           |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = '0;
  logic [2:0]  ld_funct3 = '0;
  logic [4:0]  ld_rd = '0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [31:0] err_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr),
    .ld_funct3(ld_funct3), .ld_rd(ld_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_valid(err_valid), .err_code(err_code), .err_addr(err_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one load with gnt in the first REQ cycle and rvalid the next cycle.
  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdata,
                          output logic req1, output logic [31:0] maddr1,
                          output logic wbv3, output logic [4:0] wbrd3,
                          output logic [31:0] wbd3, output logic rdy3, output logic rdy4);
    ld_valid = 1'b1; ld_addr = a; ld_funct3 = f3; ld_rd = rd;
    tick();
    ld_valid = 1'b0;
    req1 = mem_req; maddr1 = mem_addr;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
    wbv3 = wb_valid; wbrd3 = wb_rd; wbd3 = wb_data; rdy3 = ld_ready;
    tick();
    rdy4 = ld_ready;
  endtask

  task automatic test_reset();
    #2;
    total++; if (mem_req !== 1'b0)    begin bad++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
    total++; if (wb_valid !== 1'b0)   begin bad++; $display("FAIL rst_wb_valid got=%0b exp=0", wb_valid); end
    total++; if (err_valid !== 1'b0)  begin bad++; $display("FAIL rst_err_valid got=%0b exp=0", err_valid); end
    total++; if ({mem_addr, wb_data, err_addr} !== 96'd0)
      begin bad++; $display("FAIL rst_data got=%h/%h/%h exp=0", mem_addr, wb_data, err_addr); end
    total++; if ({wb_rd, err_code} !== 7'd0)
      begin bad++; $display("FAIL rst_rd_code got=%h/%h exp=0", wb_rd, err_code); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%0b exp=1", ld_ready); end
  endtask

  task automatic test_lw();
    logic req1, wbv, r3, r4; logic [31:0] ma, wd; logic [4:0] wr;
    run_load(32'h100, 3'd2, 5'd7, 32'hDEADBEEF, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (req1 !== 1'b1)        begin bad++; $display("FAIL lw_req got=%0b exp=1", req1); end
    total++; if (ma !== 32'h100)       begin bad++; $display("FAIL lw_maddr got=%h exp=00000100", ma); end
    total++; if (wbv !== 1'b1)         begin bad++; $display("FAIL lw_wb_valid got=%0b exp=1", wbv); end
    total++; if (wr !== 5'd7)          begin bad++; $display("FAIL lw_wb_rd got=%0d exp=7", wr); end
    total++; if (wd !== 32'hDEADBEEF)  begin bad++; $display("FAIL lw_wb_data got=%h exp=deadbeef", wd); end
    total++; if (wb_valid !== 1'b0)    begin bad++; $display("FAIL lw_wb_pulse got=%0b exp=0", wb_valid); end
    total++; if (r4 !== 1'b1)          begin bad++; $display("FAIL lw_ready_back got=%0b exp=1", r4); end
  endtask

  task automatic test_extend();
    logic req1, wbv, r3, r4; logic [31:0] ma, wd; logic [4:0] wr;
    run_load(32'h203, 3'd0, 5'd3, 32'h80112233, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (ma !== 32'h200)      begin bad++; $display("FAIL lb_maddr got=%h exp=00000200", ma); end
    total++; if (wd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb_data got=%h exp=ffffff80", wd); end
    run_load(32'h203, 3'd4, 5'd3, 32'h80112233, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (wd !== 32'h00000080) begin bad++; $display("FAIL lbu_data got=%h exp=00000080", wd); end
    run_load(32'h202, 3'd5, 5'd4, 32'hBEEF0000, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (wd !== 32'h0000BEEF) begin bad++; $display("FAIL lhu_data got=%h exp=0000beef", wd); end
    run_load(32'h202, 3'd1, 5'd4, 32'h80010000, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (wd !== 32'hFFFF8001) begin bad++; $display("FAIL lh_data got=%h exp=ffff8001", wd); end
    run_load(32'h201, 3'd4, 5'd5, 32'h80112233, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (wd !== 32'h00000022) begin bad++; $display("FAIL lbu1_data got=%h exp=00000022", wd); end
    run_load(32'h200, 3'd1, 5'd5, 32'h1234F00D, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (wd !== 32'hFFFFF00D) begin bad++; $display("FAIL lh0_data got=%h exp=fffff00d", wd); end
  endtask

  task automatic test_errors();
    ld_valid = 1'b1; ld_addr = 32'h101; ld_funct3 = 3'd1; ld_rd = 5'd2;
    tick();
    ld_valid = 1'b0;
    total++; if (err_valid !== 1'b1)  begin bad++; $display("FAIL mis_err_valid got=%0b exp=1", err_valid); end
    total++; if (err_code !== 2'b01)  begin bad++; $display("FAIL mis_code got=%b exp=01", err_code); end
    total++; if (err_addr !== 32'h101) begin bad++; $display("FAIL mis_addr got=%h exp=00000101", err_addr); end
    total++; if (mem_req !== 1'b0)    begin bad++; $display("FAIL mis_mem_req got=%0b exp=0", mem_req); end
    total++; if (ld_ready !== 1'b0)   begin bad++; $display("FAIL mis_ready_pulse got=%0b exp=0", ld_ready); end
    tick();
    total++; if ({err_valid, mem_req, ld_ready} !== 3'b001)
      begin bad++; $display("FAIL mis_after got=%b exp=001", {err_valid, mem_req, ld_ready}); end
    ld_valid = 1'b1; ld_addr = 32'h101; ld_funct3 = 3'd3;
    tick();
    ld_valid = 1'b0;
    total++; if ({err_valid, err_code} !== 3'b110)
      begin bad++; $display("FAIL ill_code got=%b exp=110", {err_valid, err_code}); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ill_mem_req got=%0b exp=0", mem_req); end
    tick();
    ld_valid = 1'b1; ld_addr = 32'h102; ld_funct3 = 3'd2;
    tick();
    ld_valid = 1'b0;
    total++; if ({err_valid, err_code} !== 3'b101 || err_addr !== 32'h102)
      begin bad++; $display("FAIL lw_mis got=%b/%h exp=101/00000102", {err_valid, err_code}, err_addr); end
    tick();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int n = 0;
    logic seen = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h300; ld_funct3 = 3'd2; ld_rd = 5'd9;
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      total++; if (mem_addr !== 32'h300) begin bad++; $display("FAIL to_maddr got=%h exp=00000300", mem_addr); end
      if (i == 4) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    total++; if (req_cycles !== 5) begin bad++; $display("FAIL to_req_cycles got=%0d exp=5", req_cycles); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%0b exp=0", mem_req); end
    while (!seen && n < 20) begin
      tick();
      n++;
      if (err_valid === 1'b1) seen = 1'b1;
    end
    total++; if (!seen || n != 4) begin bad++; $display("FAIL to_latency got=%0d seen=%0b exp=4", n, seen); end
    total++; if (err_code !== 2'b11 || err_addr !== 32'h300)
      begin bad++; $display("FAIL to_code got=%b/%h exp=11/00000300", err_code, err_addr); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL to_wb got=%0b exp=0", wb_valid); end
    tick();
    total++; if (ld_ready !== 1'b1 || err_valid !== 1'b0)
      begin bad++; $display("FAIL to_ready got=%0b/%0b exp=1/0", ld_ready, err_valid); end
  endtask

  task automatic test_rd0();
    logic req1, wbv, r3, r4; logic [31:0] ma, wd; logic [4:0] wr;
    run_load(32'h500, 3'd2, 5'd0, 32'hCAFEF00D, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (req1 !== 1'b1 || ma !== 32'h500)
      begin bad++; $display("FAIL rd0_req got=%0b/%h exp=1/00000500", req1, ma); end
    total++; if (wbv !== 1'b0) begin bad++; $display("FAIL rd0_wb got=%0b exp=0", wbv); end
    total++; if (r3 !== 1'b0 || r4 !== 1'b1)
      begin bad++; $display("FAIL rd0_ready got=%0b%0b exp=01", r3, r4); end
  endtask

  task automatic test_async_reset();
    logic req1, wbv, r3, r4; logic [31:0] ma, wd; logic [4:0] wr;
    ld_valid = 1'b1; ld_addr = 32'h400; ld_funct3 = 3'd2; ld_rd = 5'd6;
    tick();
    ld_valid = 1'b0;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL ar_req_pre got=%0b exp=1", mem_req); end
    #2 rst = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL ar_req_drop got=%0b exp=0", mem_req); end
    @(negedge clk); rst = 1'b1;
    tick();
    total++; if (ld_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%0b exp=1", ld_ready); end
    ld_valid = 1'b1; ld_addr = 32'h404; ld_funct3 = 3'd2; ld_rd = 5'd6;
    tick();
    ld_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
    tick();
    mem_rvalid = 1'b0;
    total++; if (wb_valid !== 1'b0 || ld_ready !== 1'b1)
      begin bad++; $display("FAIL ar_late_rvalid got=%0b/%0b exp=0/1", wb_valid, ld_ready); end
    tick();
    total++; if (wb_valid !== 1'b0 || mem_req !== 1'b0)
      begin bad++; $display("FAIL ar_idle got=%0b/%0b exp=0/0", wb_valid, mem_req); end
    run_load(32'h408, 3'd2, 5'd8, 32'h0BADC0DE, req1, ma, wbv, wr, wd, r3, r4);
    total++; if (wbv !== 1'b1 || wd !== 32'h0BADC0DE || ma !== 32'h408)
      begin bad++; $display("FAIL ar_next_lw got=%0b/%h/%h exp=1/0badc0de/00000408", wbv, wd, ma); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_extend();
    test_errors();
    test_timeout();
    test_rd0();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
